pseudo_linear_learner: RTL and testbench

- Parametrised, multi-cycle successor of the single-cycle pseudo-linear Boolean classifier/learner.
- Holds an N_IN-bit parameter vector p. For each accepted sample it:
  - computes num = popcount(p & x) and num_p = popcount(p),
  - predicts pred = ((num_p >> threshold) < num),
  - when training and pred != label, flips every p bit whose individual flip would change pred.
- Popcount and update are serialised over LANES bits per cycle, with valid/ready handshakes on both sides.
- Sits between the sample streamer and the ten per-class learner instances / argmax stage.

---
 rtl/pseudo_linear_pkg.sv | 23 ++
 rtl/pseudo_linear_learner_pl_chunk_flip.sv | 46 ++++
 rtl/pseudo_linear_learner.sv | 182 ++++++++++++++++++
 tb/tb_pseudo_linear_learner.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pseudo_linear_pkg.sv
// Shared types, default sizes and the forward decision for the pseudo-linear learner.
package pseudo_linear_pkg;

    localparam int DEF_N_IN  = 784;
    localparam int DEF_LANES = 16;
    localparam int DEF_TH_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COUNT  = 3'd1,
        ST_DECIDE = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Callers zero-extend into these fixed widths so one function serves every size.
    function automatic logic forward(input logic [31:0] num,
                                     input logic [31:0] num_p,
                                     input logic [7:0]  th);
        return ((num_p >> th) < num);
    endfunction

endpackage

// File: rtl/pseudo_linear_learner_pl_chunk_flip.sv
// One LANES-wide chunk: popcounts for COUNT, flip mask and flip count for UPDATE.
module pl_chunk_flip
    import pseudo_linear_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int TH_W  = DEF_TH_W,
    parameter int CNT_W = 10
) (
    input  logic [LANES-1:0] p_chunk_i,
    input  logic [LANES-1:0] x_chunk_i,
    input  logic [CNT_W-1:0] num_i,
    input  logic [CNT_W-1:0] nump_i,
    input  logic [TH_W-1:0]  th_i,
    input  logic             pred_i,
    output logic [LANES-1:0] flip_o,
    output logic [CNT_W-1:0] flip_cnt_o,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] set_cnt_o
);

    logic [CNT_W-1:0] num_m_s;
    logic [CNT_W-1:0] nump_m_s;

    // Each bit is judged against the frozen counts as if it alone were flipped.
    always_comb begin
        flip_o     = '0;
        flip_cnt_o = '0;
        hit_cnt_o  = '0;
        set_cnt_o  = '0;
        num_m_s    = '0;
        nump_m_s   = '0;
        for (int m = 0; m < LANES; m++) begin
            if (x_chunk_i[m]) begin
                num_m_s = p_chunk_i[m] ? (num_i - CNT_W'(1)) : (num_i + CNT_W'(1));
            end else begin
                num_m_s = num_i;
            end
            nump_m_s   = p_chunk_i[m] ? (nump_i - CNT_W'(1)) : (nump_i + CNT_W'(1));
            flip_o[m]  = pred_i ^ forward(32'(num_m_s), 32'(nump_m_s), 8'(th_i));
            flip_cnt_o = flip_cnt_o + CNT_W'(flip_o[m]);
            hit_cnt_o  = hit_cnt_o + CNT_W'(p_chunk_i[m] & x_chunk_i[m]);
            set_cnt_o  = set_cnt_o + CNT_W'(p_chunk_i[m]);
        end
    end

endmodule

// File: rtl/pseudo_linear_learner.sv
// Multi-cycle pseudo-linear Boolean classifier/learner with valid/ready handshakes.
// Optional PSEUDO_LINEAR_PARAM_LOAD_EN adds load_en/load_data to preload p in IDLE.
module pseudo_linear_learner
    import pseudo_linear_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int LANES = DEF_LANES,
    parameter int TH_W  = DEF_TH_W,
    localparam int CNT_W = $clog2(N_IN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TH_W-1:0]  threshold,
    input  logic             train_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    input  logic             in_label,
`ifdef PSEUDO_LINEAR_PARAM_LOAD_EN
    input  logic             load_en,
    input  logic [N_IN-1:0]  load_data,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_pred,
    output logic             out_err,
    output logic [CNT_W-1:0] out_flips,
    output logic [N_IN-1:0]  pm
);

    localparam int C   = N_IN / LANES;
    localparam int K_W = (C > 1) ? $clog2(C) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(C - 1);

    state_t           state_q;
    logic [N_IN-1:0]  p_q;
    logic [N_IN-1:0]  x_q;
    logic             label_q;
    logic [TH_W-1:0]  th_q;
    logic             train_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] nump_q;
    logic [K_W-1:0]   k_q;
    logic             rdy_q;
    logic             valid_q;
    logic             pred_q;
    logic             err_q;
    logic [CNT_W-1:0] flips_q;

    logic             load_s;
    logic [N_IN-1:0]  load_data_s;
    logic             accept_s;
    logic             pred_d;
    logic [LANES-1:0] p_chunk_s;
    logic [LANES-1:0] x_chunk_s;
    logic [LANES-1:0] flip_s;
    logic [CNT_W-1:0] flip_cnt_s;
    logic [CNT_W-1:0] hit_cnt_s;
    logic [CNT_W-1:0] set_cnt_s;

`ifdef PSEUDO_LINEAR_PARAM_LOAD_EN
    assign load_s      = load_en & (state_q == ST_IDLE);
    assign load_data_s = load_data;
`else
    assign load_s      = 1'b0;
    assign load_data_s = '0;
`endif

    // A load cycle suppresses acceptance so p and a new sample never collide.
    assign in_ready  = rdy_q & ~load_s;
    assign accept_s  = in_valid & in_ready;
    assign out_valid = valid_q;
    assign out_pred  = pred_q;
    assign out_err   = err_q;
    assign out_flips = flips_q;
    assign pm        = p_q;

    assign p_chunk_s = p_q[int'(k_q) * LANES +: LANES];
    assign x_chunk_s = x_q[int'(k_q) * LANES +: LANES];
    assign pred_d    = forward(32'(num_q), 32'(nump_q), 8'(th_q));

    pl_chunk_flip #(
        .LANES (LANES),
        .TH_W  (TH_W),
        .CNT_W (CNT_W)
    ) u_chunk (
        .p_chunk_i  (p_chunk_s),
        .x_chunk_i  (x_chunk_s),
        .num_i      (num_q),
        .nump_i     (nump_q),
        .th_i       (th_q),
        .pred_i     (pred_q),
        .flip_o     (flip_s),
        .flip_cnt_o (flip_cnt_s),
        .hit_cnt_o  (hit_cnt_s),
        .set_cnt_o  (set_cnt_s)
    );

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            x_q     <= '0;
            label_q <= 1'b0;
            th_q    <= '0;
            train_q <= 1'b0;
            num_q   <= '0;
            nump_q  <= '0;
            k_q     <= '0;
            rdy_q   <= 1'b1;
            valid_q <= 1'b0;
            pred_q  <= 1'b0;
            err_q   <= 1'b0;
            flips_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_s) begin
                        p_q <= load_data_s;
                    end else if (accept_s) begin
                        x_q     <= in_data;
                        label_q <= in_label;
                        th_q    <= threshold;
                        train_q <= train_en;
                        num_q   <= '0;
                        nump_q  <= '0;
                        k_q     <= '0;
                        flips_q <= '0;
                        rdy_q   <= 1'b0;
                        state_q <= ST_COUNT;
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    num_q  <= num_q + hit_cnt_s;
                    nump_q <= nump_q + set_cnt_s;
                    if (k_q == K_LAST) begin
                        state_q <= ST_DECIDE;
                    end else begin
                        k_q <= k_q + K_W'(1);
                    end
                end
                ST_DECIDE: begin
                    pred_q <= pred_d;
                    err_q  <= pred_d ^ label_q;
                    k_q    <= '0;
                    if ((pred_d ^ label_q) && train_q) begin
                        state_q <= ST_UPDATE;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                ST_UPDATE: begin
                    p_q[int'(k_q) * LANES +: LANES] <= p_chunk_s ^ flip_s;
                    flips_q <= flips_q + flip_cnt_s;
                    if (k_q == K_LAST) begin
                        state_q <= ST_DONE;
                    end else begin
                        k_q <= k_q + K_W'(1);
                    end
                end
                ST_DONE: begin
                    if (valid_q && out_ready) begin
                        valid_q <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pseudo_linear_learner.sv
// Randomised self-checking bench for pseudo_linear_learner (N_IN=16, LANES=4).
module tb_pseudo_linear_learner;

    localparam int N_IN  = 16;
    localparam int LANES = 4;
    localparam int TH_W  = 4;
    localparam int CNT_W = $clog2(N_IN + 1);
    localparam int C     = N_IN / LANES;

    logic             clk;
    logic             rst_n;
    logic [TH_W-1:0]  threshold;
    logic             train_en;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_data;
    logic             in_label;
    logic             out_valid;
    logic             out_ready;
    logic             out_pred;
    logic             out_err;
    logic [CNT_W-1:0] out_flips;
    logic [N_IN-1:0]  pm;
`ifdef PSEUDO_LINEAR_PARAM_LOAD_EN
    logic             load_en;
    logic [N_IN-1:0]  load_data;
`endif

    int tests_run;
    int tests_failed;
    logic [N_IN-1:0] model_p;

    pseudo_linear_learner #(.N_IN(N_IN), .LANES(LANES), .TH_W(TH_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .threshold (threshold),
        .train_en  (train_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_label  (in_label),
`ifdef PSEUDO_LINEAR_PARAM_LOAD_EN
        .load_en   (load_en),
        .load_data (load_data),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pred  (out_pred),
        .out_err   (out_err),
        .out_flips (out_flips),
        .pm        (pm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Prediction straight from the classifier definition.
    function automatic logic predict(input logic [N_IN-1:0] p, input logic [N_IN-1:0] x,
                                     input logic [TH_W-1:0] th);
        int hits;
        int set;
        hits = $countones(p & x);
        set  = $countones(p);
        return ((set >> th) < hits);
    endfunction

    task automatic send(input logic [N_IN-1:0] x, input logic lbl, input logic [TH_W-1:0] th,
                        input logic trn, input int hold);
        int cyc;
        int flips;
        logic pred;
        logic err;
        logic [N_IN-1:0] p_new;
        logic [N_IN-1:0] one;
        pred  = predict(model_p, x, th);
        err   = pred ^ lbl;
        p_new = model_p;
        flips = 0;
        one   = 16'h0001;
        if (err && trn) begin
            for (int m = 0; m < N_IN; m++) begin
                if (predict(model_p ^ (one << m), x, th) != pred) begin
                    p_new[m] = ~p_new[m];
                    flips++;
                end
            end
        end
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_data = x; in_label = lbl; threshold = th; train_en = trn; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = N_IN'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 32'(cyc), (err && trn) ? 32'(2 * C + 2) : 32'(C + 2));
        chk("pred", 32'(out_pred), 32'(pred));
        chk("err", 32'(out_err), 32'(err));
        chk("flips", 32'(out_flips), 32'(flips));
        chk("pm", 32'(pm), 32'(p_new));
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_pred", 32'(out_pred), 32'(pred));
            chk("hold_flips", 32'(out_flips), 32'(flips));
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("ready_back", 32'(in_ready), 32'd1);
        chk("pm_held", 32'(pm), 32'(p_new));
        model_p = p_new;
    endtask

    initial begin
        logic pr;
        tests_run = 0; tests_failed = 0;
        model_p = '0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        in_label = 1'b0; threshold = '0; train_en = 1'b0;
`ifdef PSEUDO_LINEAR_PARAM_LOAD_EN
        load_en = 1'b0; load_data = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pm", 32'(pm), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_flips", 32'(out_flips), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        send(16'h00F0, 1'b1, 4'd1, 1'b1, 0);
        chk("dir_pm1", 32'(pm), 32'h00F0);
        send(16'h00F0, 1'b1, 4'd1, 1'b1, 0);
        send(16'h00F0, 1'b0, 4'd1, 1'b1, 0);
        send(16'h00F0, 1'b0, 4'd1, 1'b0, 5);

        for (int i = 0; i < 40; i++) begin
            send(N_IN'($urandom), 1'($urandom), TH_W'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 2)));
        end

        // Force an error with training so the run reaches UPDATE, then reset mid-update.
        in_data = 16'h0F0F; threshold = 4'd1;
        pr = predict(model_p, 16'h0F0F, 4'd1);
        in_label = ~pr; train_en = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (C + 3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_pm", 32'(pm), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        model_p = '0;
        @(negedge clk); rst_n = 1'b1;
        repeat (2 * C + 4) @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        send(16'h00F0, 1'b1, 4'd1, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
